// File: rtl/wb_pkg.sv
// Shared writeback definitions: default widths, the request record and the
// round-robin pick helper used by every arbiter on shared write resources.
package wb_pkg;

  localparam int AW     = 5;
  localparam int XLEN   = 64;
  localparam int MAXREQ = 8;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Scan valid starting just after last, wrapping at n; first set bit wins.
  function automatic rr_pick_t rr_pick(input logic [MAXREQ-1:0] valid,
                                       input logic [2:0] last,
                                       input int n);
    rr_pick_t r;
    int       idx;
    r = '0;
    for (int k = 1; k <= MAXREQ; k++) begin
      idx = (int'(last) + k) % n;
      if (k <= n && !r.found && valid[idx[2:0]]) begin
        r.found = 1'b1;
        r.idx   = idx[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid requester after last.
module rr_arbiter
  import wb_pkg::*;
#(
  parameter int NREQ = 3,
  localparam int LW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [LW-1:0]   last,
  output logic [NREQ-1:0] grant,
  output logic            found,
  output logic [LW-1:0]   win
);

  logic [MAXREQ-1:0] valid_ext;
  rr_pick_t          pick;

  always_comb begin
    valid_ext             = '0;
    valid_ext[NREQ-1:0]   = valid;
    pick                  = rr_pick(valid_ext, 3'(last), NREQ);
    found                 = pick.found;
    win                   = LW'(pick.idx);
    grant                 = '0;
    if (pick.found) grant[win] = 1'b1;
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the single register-file write port among NREQ writeback units
// and keeps the pending-write scoreboard that decode uses for hazard checks.
module regfile_wb_scheduler #(
  parameter int NREQ = 3,
  parameter int XLEN = wb_pkg::XLEN,
  parameter int AW   = wb_pkg::AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd,
  output logic                 issue_ready,
  input  logic [AW-1:0]        rs1_addr,
  input  logic [AW-1:0]        rs2_addr,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic [31:0]          busy_vec
);

  localparam int LW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NREG = 1 << AW;

  logic [LW-1:0]   last;
  logic [LW-1:0]   win;
  logic [NREQ-1:0] grant;
  logic            found;
  logic            xfer_p0;
  logic [AW-1:0]   rd_p0;
  logic [XLEN-1:0] data_p0;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            set_en;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .valid (req_valid),
    .last  (last),
    .grant (grant),
    .found (found),
    .win   (win)
  );

  // Grants are suppressed while reset is asserted so nothing is handed out.
  assign req_ready = rst ? grant : '0;
  assign xfer_p0   = rst && found;

  always_comb begin
    rd_p0   = req_rd[int'(win)*AW +: AW];
    data_p0 = req_data[int'(win)*XLEN +: XLEN];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= LW'(NREQ - 1);
    end else if (xfer_p0) begin
      last <= win;
    end
  end

  // ---- p0 -> p1: registered write port (x0 writes are granted but dropped)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= xfer_p0 && (rd_p0 != '0);
      if (xfer_p0) begin
        rf_waddr <= rd_p0;
        rf_wdata <= data_p0;
      end
    end
  end

  // Registered busy only: a register being written this cycle still blocks
  // a new writer until the following cycle.
  assign issue_ready = !flush && ((issue_rd == '0) || !busy[issue_rd]);
  assign set_en      = issue_valid && issue_ready && (issue_rd != '0);

  always_comb begin
    busy_nxt = busy;
    if (rf_we)  busy_nxt[rf_waddr] = 1'b0;
    if (set_en) busy_nxt[issue_rd] = 1'b1;
    if (flush)  busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];
  assign busy_vec = 32'(busy);

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: vector table plus hand sequences.
module tb_regfile_wb_scheduler;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int XLEN = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic                 issue_valid;
  logic [AW-1:0]        issue_rd;
  logic                 issue_ready;
  logic [AW-1:0]        rs1_addr;
  logic [AW-1:0]        rs2_addr;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic                 rf_we;
  logic [AW-1:0]        rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic [31:0]          busy_vec;

  int checks   = 0;
  int failures = 0;

  regfile_wb_scheduler #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .busy_vec    (busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  rs1;
    logic [2:0]  e_ready;
    logic        e_iready;
    logic        e_rs1;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [63:0] e_wdata;
    logic [31:0] e_busy;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(logic [2:0] valid, logic [4:0] rd, logic [63:0] data,
                              logic iv, logic [4:0] ird, logic [4:0] rs1,
                              logic [2:0] er, logic ei, logic ers1,
                              logic ewe, logic [4:0] ewa, logic [63:0] ewd,
                              logic [31:0] eb);
    vec_t v;
    v.valid = valid; v.rd = rd; v.data = data; v.iv = iv; v.ird = ird; v.rs1 = rs1;
    v.e_ready = er; v.e_iready = ei; v.e_rs1 = ers1;
    v.e_we = ewe; v.e_waddr = ewa; v.e_wdata = ewd; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Requester i presents rd+i and data+i so the written values identify the winner.
  task automatic set_req(input logic [2:0] v, input logic [4:0] rd, input logic [63:0] d);
    req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      req_rd[i*AW +: AW]       = 5'(rd + 5'(i));
      req_data[i*XLEN +: XLEN] = d + 64'(i);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_rd = '0;
    rs1_addr = '0; rs2_addr = '0;
    set_req(3'b111, 5'd20, 64'h500);

    tbl[0]  = mk(3'b000, 0, 0,              1, 5, 5, 3'b000, 1, 0, 0, 0,  0,              32'h20);
    tbl[1]  = mk(3'b010, 4, 64'hDEADBEEE,   0, 5, 5, 3'b010, 0, 1, 1, 5,  64'hDEADBEEF,   32'h20);
    tbl[2]  = mk(3'b000, 0, 0,              0, 5, 5, 3'b000, 0, 1, 0, 0,  0,              32'h0);
    tbl[3]  = mk(3'b000, 0, 0,              0, 5, 5, 3'b000, 1, 0, 0, 0,  0,              32'h0);
    tbl[4]  = mk(3'b111, 10, 64'h100,       0, 0, 0, 3'b100, 1, 0, 1, 12, 64'h102,        32'h0);
    tbl[5]  = mk(3'b111, 10, 64'h100,       0, 0, 0, 3'b001, 1, 0, 1, 10, 64'h100,        32'h0);
    tbl[6]  = mk(3'b111, 10, 64'h100,       0, 0, 0, 3'b010, 1, 0, 1, 11, 64'h101,        32'h0);
    tbl[7]  = mk(3'b111, 10, 64'h100,       0, 0, 0, 3'b100, 1, 0, 1, 12, 64'h102,        32'h0);
    tbl[8]  = mk(3'b111, 10, 64'h100,       0, 0, 0, 3'b001, 1, 0, 1, 10, 64'h100,        32'h0);
    tbl[9]  = mk(3'b111, 10, 64'h100,       0, 0, 0, 3'b010, 1, 0, 1, 11, 64'h101,        32'h0);
    tbl[10] = mk(3'b101, 10, 64'h100,       0, 0, 0, 3'b100, 1, 0, 1, 12, 64'h102,        32'h0);
    tbl[11] = mk(3'b101, 10, 64'h100,       0, 0, 0, 3'b001, 1, 0, 1, 10, 64'h100,        32'h0);
    tbl[12] = mk(3'b101, 10, 64'h100,       0, 0, 0, 3'b100, 1, 0, 1, 12, 64'h102,        32'h0);
    tbl[13] = mk(3'b000, 0, 0,              0, 0, 0, 3'b000, 1, 0, 0, 0,  0,              32'h0);
    tbl[14] = mk(3'b100, 30, 64'h1232,      0, 0, 0, 3'b100, 1, 0, 0, 0,  0,              32'h0);

    // Reset held with all requesters valid
    #1;
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_busy", 64'(busy_vec), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    tick;
    chk("rst_we_clk", 64'(rf_we), 64'd0);
    chk("rst_ready_clk", 64'(req_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("first_grant", 64'(req_ready), 64'b001);
    tick;
    chk("first_we", 64'(rf_we), 64'd1);
    chk("first_waddr", 64'(rf_waddr), 64'd20);
    chk("first_wdata", rf_wdata, 64'h500);

    // Fresh reset with no requests: last = NREQ-1, empty scoreboard
    rst = 1'b0;
    set_req(3'b000, 0, 0);
    #1;
    chk("rst_we_drop", 64'(rf_we), 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      set_req(tbl[i].valid, tbl[i].rd, tbl[i].data);
      issue_valid = tbl[i].iv;
      issue_rd    = tbl[i].ird;
      rs1_addr    = tbl[i].rs1;
      #1;
      chk($sformatf("v%0d_ready", i),  64'(req_ready),   64'(tbl[i].e_ready));
      chk($sformatf("v%0d_iready", i), 64'(issue_ready), 64'(tbl[i].e_iready));
      chk($sformatf("v%0d_rs1", i),    64'(rs1_busy),    64'(tbl[i].e_rs1));
      tick;
      chk($sformatf("v%0d_we", i), 64'(rf_we), 64'(tbl[i].e_we));
      if (tbl[i].e_we) begin
        chk($sformatf("v%0d_waddr", i), 64'(rf_waddr), 64'(tbl[i].e_waddr));
        chk($sformatf("v%0d_wdata", i), rf_wdata, tbl[i].e_wdata);
      end
      chk($sformatf("v%0d_busy", i), 64'(busy_vec), 64'(tbl[i].e_busy));
    end

    // WAW: second issue of rd=7 blocked until the cycle after its write
    set_req(3'b000, 0, 0);
    rs1_addr = '0;
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1; chk("waw_a_iready", 64'(issue_ready), 64'd1);
    tick; chk("waw_a_busy", 64'(busy_vec), 64'h80);
    #1; chk("waw_b_iready", 64'(issue_ready), 64'd0);
    issue_rd = 5'd0;
    #1; chk("x0_iready", 64'(issue_ready), 64'd1);
    tick; chk("x0_busy", 64'(busy_vec), 64'h80);
    issue_rd = 5'd7;
    set_req(3'b001, 7, 64'h77);
    #1;
    chk("waw_c_iready", 64'(issue_ready), 64'd0);
    chk("waw_c_ready", 64'(req_ready), 64'b001);
    tick;
    set_req(3'b000, 0, 0);
    chk("waw_d_we", 64'(rf_we), 64'd1);
    chk("waw_d_waddr", 64'(rf_waddr), 64'd7);
    #1; chk("waw_d_iready", 64'(issue_ready), 64'd0);
    tick; chk("waw_d_busy", 64'(busy_vec), 64'h0);
    #1; chk("waw_e_iready", 64'(issue_ready), 64'd1);
    tick; chk("waw_e_busy", 64'(busy_vec), 64'h80);

    // Flush in the cycle a write to reg 9 is granted
    issue_rd = 5'd3; tick;
    issue_rd = 5'd9; tick;
    chk("pre_flush_busy", 64'(busy_vec), 64'h288);
    issue_rd = 5'd20; flush = 1'b1; rs2_addr = 5'd3;
    set_req(3'b010, 8, 64'h98);
    #1;
    chk("flush_iready", 64'(issue_ready), 64'd0);
    chk("flush_ready", 64'(req_ready), 64'b010);
    chk("flush_rs2", 64'(rs2_busy), 64'd1);
    chk("flush_rs1_x0", 64'(rs1_busy), 64'd0);
    tick;
    flush = 1'b0; issue_valid = 1'b0;
    chk("flush_busy", 64'(busy_vec), 64'h0);
    chk("flush_we", 64'(rf_we), 64'd1);
    chk("flush_waddr", 64'(rf_waddr), 64'd9);
    chk("flush_wdata", rf_wdata, 64'h99);

    // Asynchronous reset while a write is on the port
    rst = 1'b0;
    #1;
    chk("mid_rst_we", 64'(rf_we), 64'd0);
    chk("mid_rst_waddr", 64'(rf_waddr), 64'd0);
    chk("mid_rst_wdata", rf_wdata, 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    tick;
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
